// File: rtl/commit_queue.sv
// commit_queue -- in-order retirement queue in front of the commit stage.
//
// Each issued instruction gets a transaction ID, which is its slot index
// (the tail pointer). Functional-unit writebacks may arrive out of order
// and mark their slot done. The two oldest slots are presented on the
// commit ports, and they retire in order when the commit stage acks them.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   flush_i             discard every entry (beats issue/writeback/retire)
//   issue_valid_i       instruction offered on issue_instr_i
//   issue_instr_i       scoreboard entry to allocate
//   issue_ready_o       an offered instruction is accepted this cycle
//   issue_trans_id_o    ID the offered instruction will receive
//   wb_valid_i          per-port writeback strobe
//   wb_trans_id_i       per-port target ID
//   wb_data_i           per-port 64-bit result
//   wb_ex_i             per-port exception
//   commit_instr_o      [0] = head entry, [1] = head+1 entry
//   commit_ack_i        per-port retire acknowledge from the commit stage
//   empty_o             queue holds no entries

typedef struct packed {
  logic [63:0] cause;
  logic [63:0] tval;
  logic        valid;
} exception_t;

typedef struct packed {
  logic [63:0] pc;
  logic [3:0]  fu;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [63:0] result;
  logic        valid;
  exception_t  ex;
} scoreboard_entry_t;

module commit_queue #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         issue_valid_i,
  input  scoreboard_entry_t                            issue_instr_i,
  output logic                                         issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                 wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
  output logic                                         empty_o
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  // Control state
  logic [TRANS_ID_BITS-1:0] r_head;
  logic [TRANS_ID_BITS-1:0] r_tail;
  logic [CNT_W-1:0]         r_count;
  logic [NR_ENTRIES-1:0]    r_occ;
  logic [NR_ENTRIES-1:0]    r_done;

  // Payload storage; never reset, qualified by r_occ/r_done
  scoreboard_entry_t r_mem [NR_ENTRIES];

  logic                     w_issue_fire;
  logic [TRANS_ID_BITS-1:0] w_head1;
  logic                     w_vld0;
  logic                     w_vld1;
  logic                     w_ack0;
  logic                     w_ack1;
  logic [NR_WB_PORTS-1:0]   w_wb_hit;
  logic [CNT_W-1:0]         w_count_next;
  logic [TRANS_ID_BITS-1:0] w_head_adv;

  assign issue_ready_o    = (r_count < CNT_W'(NR_ENTRIES)) && !flush_i;
  assign issue_trans_id_o = r_tail;
  assign w_issue_fire     = issue_valid_i && issue_ready_o;
  assign empty_o          = (r_count == '0);

  // Second commit slot wraps naturally with the pointer width
  assign w_head1 = r_head + TRANS_ID_BITS'(1);
  assign w_vld0  = r_occ[r_head]  && r_done[r_head];
  assign w_vld1  = r_occ[w_head1] && r_done[w_head1];

  // Port 1 may only retire together with port 0 to keep retirement in order
  assign w_ack0 = commit_ack_i[0] && w_vld0;
  assign w_ack1 = commit_ack_i[1] && w_ack0 && w_vld1;

  assign w_head_adv   = TRANS_ID_BITS'(w_ack0) + TRANS_ID_BITS'(w_ack1);
  assign w_count_next = r_count + CNT_W'(w_issue_fire)
                      - CNT_W'(w_ack0) - CNT_W'(w_ack1);

  // A writeback only lands on a live entry; flush/reset kill it outright
  always_comb begin
    w_wb_hit = '0;
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      w_wb_hit[k] = wb_valid_i[k] && r_occ[wb_trans_id_i[k]] && !flush_i && !rst_i;
    end
  end

  always_comb begin
    commit_instr_o       = '0;
    commit_instr_o[0]       = r_mem[r_head];
    commit_instr_o[0].valid = w_vld0;
    commit_instr_o[1]       = r_mem[w_head1];
    commit_instr_o[1].valid = w_vld1;
  end

  // Control: pointers, count, occupied/done
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_occ   <= '0;
      r_done  <= '0;
    end else begin
      if (w_issue_fire) begin
        r_occ[r_tail]  <= 1'b1;
        // Fetch/decode exceptions need no writeback to become committable
        r_done[r_tail] <= issue_instr_i.ex.valid;
        r_tail         <= r_tail + TRANS_ID_BITS'(1);
      end
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (w_wb_hit[k]) begin
          r_done[wb_trans_id_i[k]] <= 1'b1;
        end
      end
      // Retire clears last so it overrides a late writeback to the head slot
      if (w_ack0) begin
        r_occ[r_head]  <= 1'b0;
        r_done[r_head] <= 1'b0;
      end
      if (w_ack1) begin
        r_occ[w_head1]  <= 1'b0;
        r_done[w_head1] <= 1'b0;
      end
      r_head  <= r_head + w_head_adv;
      r_count <= w_count_next;
    end
  end

  // Payload: the issue slot is never occupied, so it cannot collide with a
  // writeback. Ports are walked in ascending order so the highest index wins.
  always_ff @(posedge clk_i) begin
    if (w_issue_fire) begin
      r_mem[r_tail] <= issue_instr_i;
    end
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      if (w_wb_hit[k]) begin
        r_mem[wb_trans_id_i[k]].result <= wb_data_i[k];
        if (wb_ex_i[k].valid) begin
          r_mem[wb_trans_id_i[k]].ex <= wb_ex_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Testbench for commit_queue: directed vector table followed by a
// randomized run compared against a queue-based reference model.
module tb_commit_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_i;
  logic                    flush_i;
  logic                    issue_valid_i;
  scoreboard_entry_t       issue_instr_i;
  logic                    issue_ready_o;
  logic [2:0]              issue_trans_id_o;
  logic [3:0]              wb_valid_i;
  logic [3:0][2:0]         wb_trans_id_i;
  logic [3:0][63:0]        wb_data_i;
  exception_t [3:0]        wb_ex_i;
  scoreboard_entry_t [1:0] commit_instr_o;
  logic [1:0]              commit_ack_i;
  logic                    empty_o;

  commit_queue dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_instr_i    (issue_instr_i),
    .issue_ready_o    (issue_ready_o),
    .issue_trans_id_o (issue_trans_id_o),
    .wb_valid_i       (wb_valid_i),
    .wb_trans_id_i    (wb_trans_id_i),
    .wb_data_i        (wb_data_i),
    .wb_ex_i          (wb_ex_i),
    .commit_instr_o   (commit_instr_o),
    .commit_ack_i     (commit_ack_i),
    .empty_o          (empty_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic           rst, flush, iv, iexv;
    logic [7:0]     icause;
    logic [3:0]     wbv;
    logic [3:0][2:0] wbid;
    logic [3:0][7:0] wbd;
    logic [1:0]     ack;
    logic           chk;
    logic           e_ready;
    logic [2:0]     e_tid;
    logic           e_empty, e_v0, e_v1;
    logic [7:0]     e_res0, e_cause0;
  } vec_t;

  function automatic vec_t V(input logic rst, flush, iv, iexv, input logic [7:0] icause,
                             input logic [3:0] wbv, input logic [11:0] wbid,
                             input logic [31:0] wbd, input logic [1:0] ack,
                             input logic c, ready, input logic [2:0] tid,
                             input logic empty, v0, v1, input logic [7:0] res0, cause0);
    vec_t r;
    r.rst = rst; r.flush = flush; r.iv = iv; r.iexv = iexv; r.icause = icause;
    r.wbv = wbv; r.wbid = wbid; r.wbd = wbd; r.ack = ack;
    r.chk = c; r.e_ready = ready; r.e_tid = tid; r.e_empty = empty;
    r.e_v0 = v0; r.e_v1 = v1; r.e_res0 = res0; r.e_cause0 = cause0;
    return r;
  endfunction

  vec_t vec [64];
  int   nv;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]        id;
    logic              done;
    scoreboard_entry_t e;
  } mentry_t;

  mentry_t mq[$];
  int      nid;

  // Applies the edge using the inputs currently driven on the DUT
  task automatic model_step();
    bit fire, a0, a1;
    mentry_t m;
    if (rst_i || flush_i) begin
      mq.delete();
      nid = 0;
      return;
    end
    fire = issue_valid_i && (mq.size() < 8);
    a0 = commit_ack_i[0] && (mq.size() > 0) && mq[0].done;
    a1 = commit_ack_i[1] && a0 && (mq.size() > 1) && mq[1].done;
    for (int k = 0; k < 4; k++) begin
      if (wb_valid_i[k]) begin
        foreach (mq[j]) begin
          if (mq[j].id == wb_trans_id_i[k]) begin
            mq[j].done = 1'b1;
            mq[j].e.result = wb_data_i[k];
            if (wb_ex_i[k].valid) mq[j].e.ex = wb_ex_i[k];
          end
        end
      end
    end
    if (fire) begin
      m.id = 3'(nid);
      m.done = issue_instr_i.ex.valid;
      m.e = issue_instr_i;
      mq.push_back(m);
      nid = (nid + 1) % 8;
    end
    if (a0) void'(mq.pop_front());
    if (a1) void'(mq.pop_front());
  endtask

  task automatic model_check();
    bit mv;
    chk("ready", 64'(issue_ready_o), 64'((mq.size() < 8) && !flush_i));
    chk("trans_id", 64'(issue_trans_id_o), 64'(nid));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0));
    for (int p = 0; p < 2; p++) begin
      mv = (mq.size() > p) && mq[p].done;
      chk($sformatf("valid%0d", p), 64'(commit_instr_o[p].valid), 64'(mv));
      if (mv) begin
        chk($sformatf("pc%0d", p), commit_instr_o[p].pc, mq[p].e.pc);
        chk($sformatf("result%0d", p), commit_instr_o[p].result, mq[p].e.result);
        chk($sformatf("exv%0d", p), 64'(commit_instr_o[p].ex.valid), 64'(mq[p].e.ex.valid));
        chk($sformatf("cause%0d", p), commit_instr_o[p].ex.cause, mq[p].e.ex.cause);
      end
    end
  endtask

  initial begin
    // Plan: 3 issues, out-of-order writeback, dual ack
    nv = 0;
    vec[nv++] = V(1,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 0,0,0,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,1,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,1,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,1,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,2,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0001,12'd2,32'h22,2'b00, 1,1,3,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0001,12'd0,32'h20,2'b00, 1,1,3,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0001,12'd1,32'h21,2'b00, 1,1,3,0,1,0,8'h20,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b11, 1,1,3,0,1,1,8'h20,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,3,0,1,0,8'h22,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b01, 1,1,3,0,1,0,8'h22,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,3,1,0,0,8'h00,8'h0);
    // Issue with exception, committable without writeback; held until ack
    vec[nv++] = V(0,0,1,1,2, 4'b0000,12'd0,32'h0,2'b00, 1,1,3,1,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,4,0,1,0,8'h00,8'h2);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b01, 1,1,4,0,1,0,8'h00,8'h2);
    // Dual ack with only head done retires one entry
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,4,1,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,5,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0001,12'd4,32'h44,2'b00, 1,1,6,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b11, 1,1,6,0,1,0,8'h44,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,6,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0001,12'd5,32'h55,2'b00, 1,1,6,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b01, 1,1,6,0,1,0,8'h55,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,6,1,0,0,8'h00,8'h0);
    // Reset, fill to full, held issue, wrap, same-ID writeback
    vec[nv++] = V(1,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 0,0,0,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,1,0,0,8'h00,8'h0);
    for (int t = 0; t < 8; t++)
      vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,3'(t),(t == 0),0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b1011,12'h820,32'h0B000A30,2'b00, 1,0,0,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b01, 1,0,0,0,1,0,8'h30,8'h0);
    vec[nv++] = V(0,0,1,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0111,12'h0D1,32'h00333231,2'b00, 1,0,1,0,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b11, 1,0,1,0,1,1,8'h31,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b01, 1,1,1,0,1,1,8'h33,8'h0);
    // Five entries live; flush with issue and writeback in the same cycle
    vec[nv++] = V(0,1,1,0,0, 4'b0001,12'd5,32'h55,2'b00, 1,0,1,0,1,0,8'h0B,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,1,0,0,8'h00,8'h0);
    vec[nv++] = V(0,0,0,0,0, 4'b0000,12'd0,32'h0,2'b00, 1,1,0,1,0,0,8'h00,8'h0);

    for (int i = 0; i < nv; i++) begin
      rst_i         = vec[i].rst;
      flush_i       = vec[i].flush;
      issue_valid_i = vec[i].iv;
      issue_instr_i = '0;
      issue_instr_i.pc       = 64'h1000 + 64'(i);
      issue_instr_i.ex.valid = vec[i].iexv;
      issue_instr_i.ex.cause = 64'(vec[i].icause);
      wb_valid_i    = vec[i].wbv;
      for (int k = 0; k < 4; k++) begin
        wb_trans_id_i[k] = vec[i].wbid[k];
        wb_data_i[k]     = 64'(vec[i].wbd[k]);
        wb_ex_i[k]       = '0;
      end
      commit_ack_i  = vec[i].ack;
      #1;
      if (vec[i].chk) begin
        chk($sformatf("v%0d ready", i), 64'(issue_ready_o), 64'(vec[i].e_ready));
        chk($sformatf("v%0d tid", i), 64'(issue_trans_id_o), 64'(vec[i].e_tid));
        chk($sformatf("v%0d empty", i), 64'(empty_o), 64'(vec[i].e_empty));
        chk($sformatf("v%0d valid0", i), 64'(commit_instr_o[0].valid), 64'(vec[i].e_v0));
        chk($sformatf("v%0d valid1", i), 64'(commit_instr_o[1].valid), 64'(vec[i].e_v1));
        if (vec[i].e_v0) begin
          chk($sformatf("v%0d result0", i), commit_instr_o[0].result, 64'(vec[i].e_res0));
          chk($sformatf("v%0d cause0", i), commit_instr_o[0].ex.cause, 64'(vec[i].e_cause0));
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    // ---------------- randomized run against the model ----------------
    mq.delete();
    nid = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_i         = (i == 0) || ($urandom_range(0, 299) == 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      issue_valid_i = ($urandom_range(0, 9) < 6);
      issue_instr_i.pc       = {$urandom, $urandom};
      issue_instr_i.fu       = 4'($urandom);
      issue_instr_i.op       = 7'($urandom);
      issue_instr_i.rd       = 5'($urandom);
      issue_instr_i.result   = {$urandom, $urandom};
      issue_instr_i.valid    = 1'b0;
      issue_instr_i.ex.valid = ($urandom_range(0, 7) == 0);
      issue_instr_i.ex.cause = 64'($urandom_range(0, 15));
      issue_instr_i.ex.tval  = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
        wb_valid_i[k]     = ($urandom_range(0, 9) < 3);
        wb_trans_id_i[k]  = 3'($urandom);
        wb_data_i[k]      = {$urandom, $urandom};
        wb_ex_i[k].valid  = ($urandom_range(0, 7) == 0);
        wb_ex_i[k].cause  = 64'($urandom_range(16, 31));
        wb_ex_i[k].tval   = {$urandom, $urandom};
      end
      commit_ack_i = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      #1;
      if (i > 0) model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
